// File: rtl/tt_um_divide_reconstructor_pkg.sv
// Shared constants and types for the divide reconstructor (q*d + r) tile.
// Pin indices and the error code match the companion 4-bit divider tile.
package recon_pkg;

    localparam int NIB_W = 4;
    localparam int RES_W = 8;
    localparam int STEPS = 4;
    localparam int CNT_W = 3;

    localparam logic [RES_W-1:0] ERR_CODE   = 8'hFF;
    localparam logic [7:0]       UIO_OE_VAL = 8'b1110_0000;
    localparam logic [CNT_W-1:0] CNT_LAST   = 3'(STEPS - 1);

    localparam int UIO_START = 4;
    localparam int UIO_BUSY  = 5;
    localparam int UIO_DONE  = 6;
    localparam int UIO_ERR   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A valid divider triple needs a nonzero divisor and a remainder below it.
    function automatic logic triple_err(input logic [NIB_W-1:0] r,
                                        input logic [NIB_W-1:0] d);
        return (d == {NIB_W{1'b0}}) || (r >= d);
    endfunction

endpackage

// File: rtl/tt_um_divide_reconstructor_shift_add_step.sv
// One combinational shift-add multiply step: conditionally add the
// multiplicand, then advance multiplicand left and multiplier right.
module shift_add_step
    import recon_pkg::*;
(
    input  logic [RES_W-1:0] i_acc,
    input  logic [RES_W-1:0] i_mcand,
    input  logic [NIB_W-1:0] i_mplier,
    output logic [RES_W-1:0] o_acc,
    output logic [RES_W-1:0] o_mcand,
    output logic [NIB_W-1:0] o_mplier
);

    // Accumulate and shift for a single multiplier bit.
    always_comb begin
        o_acc    = i_acc;
        o_mcand  = {i_mcand[RES_W-2:0], 1'b0};
        o_mplier = {1'b0, i_mplier[NIB_W-1:1]};
        if (i_mplier[0]) begin
            o_acc = i_acc + i_mcand;
        end else begin
            o_acc = i_acc;
        end
    end

endmodule

// File: rtl/tt_um_divide_reconstructor.sv
// Sequential reconstructor: dividend = q*d + r over four shift-add steps,
// with start/busy/done/err handshake on the bidirectional pins.
module tt_um_divide_reconstructor
    import recon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             r_state;
    logic               r_start_q;
    logic [RES_W-1:0]   r_acc;
    logic [RES_W-1:0]   r_mcand;
    logic [NIB_W-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [RES_W-1:0]   r_uo;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [NIB_W-1:0]   w_q;
    logic [NIB_W-1:0]   w_r;
    logic [NIB_W-1:0]   w_d;
    logic               w_start_edge;
    logic [RES_W-1:0]   w_acc_nxt;
    logic [RES_W-1:0]   w_mcand_nxt;
    logic [NIB_W-1:0]   w_mplier_nxt;
    logic               w_unused_uio;

    assign w_q          = ui_in[7:4];
    assign w_r          = ui_in[3:0];
    assign w_d          = uio_in[3:0];
    assign w_start_edge = uio_in[UIO_START] & ~r_start_q;
    assign w_unused_uio = &{1'b0, uio_in[7:5]};

    shift_add_step u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_nxt),
        .o_mcand  (w_mcand_nxt),
        .o_mplier (w_mplier_nxt)
    );

    // Control FSM, operand registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_acc     <= 8'h00;
            r_mcand   <= 8'h00;
            r_mplier  <= 4'h0;
            r_cnt     <= 3'd0;
            r_uo      <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else if (ena) begin
            r_start_q <= uio_in[UIO_START];
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_edge) begin
                        r_acc    <= {4'h0, w_r};
                        r_mcand  <= {4'h0, w_d};
                        r_mplier <= w_q;
                        r_cnt    <= 3'd0;
                        r_err    <= triple_err(w_r, w_d);
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    // A zero multiplicand can only come from d == 0.
                    if (r_mcand == 8'h00) begin
                        r_uo    <= ERR_CODE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= w_mcand_nxt;
                        r_mplier <= w_mplier_nxt;
                        r_cnt    <= r_cnt + 3'd1;
                        if (r_cnt == CNT_LAST) begin
                            r_uo    <= w_acc_nxt;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = r_uo;
    assign uio_out = {r_err, r_done, r_busy, 5'b0_0000};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_divide_reconstructor.sv
// Directed bench for the divide reconstructor with an expected-result queue.
module tb_tt_um_divide_reconstructor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors     = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];

    tt_um_divide_reconstructor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model(input int q, input int r, input int d);
        logic       e;
        logic [7:0] v;
        e = (d == 0) || (r >= d);
        v = (d == 0) ? 8'hFF : 8'(q * d + r);
        return {e, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int q, input int r, input int d);
        ui_in  = {4'(q), 4'(r)};
        uio_in = {3'b000, 1'b1, 4'(d)};
        exp_q.push_back(model(q, r, d));
    endtask

    // Called just after E0: waits for done, checks latency, busy length and result.
    task automatic collect(input string tag, input int exp_lat, input int exp_busy);
        int lat;
        int busy_cnt;
        logic [8:0] e;
        lat = 0;
        busy_cnt = 0;
        while (uio_out[6] !== 1'b1 && lat < 30) begin
            if (uio_out[5] === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_done"}, 32'(uio_out[6]), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busycyc"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_busy0"}, 32'(uio_out[5]), 32'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
        check({tag, "_res"}, 32'(uo_out), 32'(e[7:0]));
        check({tag, "_err"}, 32'(uio_out[7]), 32'(e[8]));
    endtask

    task automatic run_op(input string tag, input int q, input int r, input int d, input int lat);
        drive_start(q, r, d);
        tick();
        uio_in[4] = 1'b0;
        collect(tag, lat, lat);
    endtask

    initial begin
        int busy_cnt;
        int lat;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        tick();
        check("rst_uo", 32'(uo_out), 32'h00);
        check("rst_uio", 32'(uio_out), 32'h00);
        check("uio_oe", 32'(uio_oe), 32'hE0);
        rst_n = 1'b1;
        tick();
        check("idle_uio", 32'(uio_out), 32'h00);

        run_op("basic", 5, 2, 3, 4);
        tick();
        check("hold_res", 32'(uo_out), 32'h11);
        check("hold_done", 32'(uio_out[6]), 32'd1);

        run_op("max", 15, 14, 15, 4);
        run_op("dzero", 9, 7, 0, 1);
        tick();
        check("dzero_nobusy", 32'(uio_out[5]), 32'd0);
        run_op("rged", 2, 5, 3, 4);
        run_op("zeroq", 0, 1, 2, 4);

        // start held high for ten cycles: exactly one operation
        drive_start(6, 3, 7);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uio_out[5] === 1'b1) busy_cnt++;
        end
        check("held_busycyc", 32'(busy_cnt), 32'd4);
        uio_in[4] = 1'b0;
        tick();
        check("held_res", 32'(uo_out), 32'(model(6, 3, 7) & 9'h0FF));
        void'(exp_q.pop_front());

        // second start pulse at E2 is ignored
        drive_start(3, 1, 4);
        tick();
        uio_in[4] = 1'b0;
        tick();
        ui_in  = 8'hFF;
        uio_in = 8'h1F;
        tick();
        uio_in = 8'h00;
        collect("restart", 2, 2);
        tick();
        tick();
        check("restart_idle", 32'(uio_out[5]), 32'd0);
        check("restart_keep", 32'(uo_out), 32'h0D);

        // ena low for three cycles after E1 stretches latency to seven
        drive_start(7, 4, 9);
        tick();
        uio_in[4] = 1'b0;
        tick();
        ena = 1'b0;
        tick();
        tick();
        tick();
        ena = 1'b1;
        lat = 4;
        while (uio_out[6] !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        check("ena_lat", 32'(lat), 32'd7);
        check("ena_res", 32'(uo_out), 32'(model(7, 4, 9) & 9'h0FF));
        void'(exp_q.pop_front());

        // start pulse seen only while ena is low is lost
        ena = 1'b0;
        uio_in = 8'h13;
        tick();
        uio_in = 8'h03;
        tick();
        ena = 1'b1;
        tick();
        check("ena_lost", 32'(uio_out[5]), 32'd0);

        // asynchronous reset at E2 drops the operation
        drive_start(11, 2, 13);
        tick();
        uio_in[4] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_uo", 32'(uo_out), 32'h00);
        check("arst_uio", 32'(uio_out), 32'h00);
        void'(exp_q.pop_back());
        tick();
        rst_n = 1'b1;
        tick();
        run_op("postrst", 1, 0, 1, 4);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tt_um_divide_reconstructor.md
# tt_um_divide_reconstructor

Sequential 4×4 shift-add reconstructor: given quotient q, remainder r and divisor d, computes dividend = q·d + r over four clock cycles. It is the inverse companion to the 4-bit unsigned divider tile and checks or regenerates divider results on the same TinyTapeout pin map. Start/busy/done handshake on the bidirectional pins; result on `uo_out`.

## Interface
Parameters:
- none; widths are fixed by package constants.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  clock enable; low → every register holds.
- `ui_in`  in  8  [7:4] quotient q, [3:0] remainder r.
- `uio_in`  in  8  [3:0] divisor d, [4] start; [7:5] ignored.
- `uo_out`  out  8  reconstructed dividend, or 8'hFF on error.
- `uio_out`  out  8  [5] busy, [6] done, [7] err; [4:0] = 0.
- `uio_oe`  out  8  constant 8'b1110_0000.

## Operation
- States: IDLE, MULT, DONE. Reset → IDLE.
- start_edge = start & ~start_q; start_q is a register updated on every enabled cycle.
- IDLE or DONE, start_edge (capture edge E0):
  - latch acc = {4'b0, r}, mcand = {4'b0, d}, mplier = q, cnt = 0.
  - Set err = (d == 0) | (r >= d).
  - Set busy = 1, done = 0, state → MULT.
- MULT, each enabled edge:
  - if mplier[0], acc += mcand (8-bit, never overflows: max 15·15+15 = 240).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - On the 4th step: `uo_out` ← final acc, busy = 0, done = 1, state → DONE.
- d == 0: MULT is skipped. At E1, `uo_out` = 8'hFF, err = 1, done = 1, state → DONE.
- r >= d with d ≠ 0: the full result is still computed and output; err = 1 flags an inconsistent triple.
- start_edge during MULT is ignored; start_q still tracks the pin.
- Holding start high gives exactly one operation.
- `uo_out`, err and done hold in DONE until the next capture edge.

## Timing
- Reset values: `uo_out` = 0, busy = 0, done = 0, err = 0, start_q = 0, acc/mcand/mplier/cnt = 0, state IDLE.
- Latency:
  - Normal: operands sampled at E0; result, done = 1 and busy = 0 become visible after E4 (4 cycles).
  - d == 0: result visible after E1.
- Throughput: the next start_edge is accepted at E4+1 at the earliest. A start_edge coinciding with E4 is ignored, because state is still MULT.
- ena = 0 for k cycles mid-operation extends latency by exactly k. Edge detection also freezes, so a start pulse seen only while ena = 0 is lost.
- rst_n asserted mid-MULT: all outputs return to reset values immediately (asynchronous) and the operation is dropped.
- Operands are sampled only at E0; input changes during MULT have no effect.

## Structure
- Shared package `recon_pkg`:
  - state enum {IDLE, MULT, DONE}.
  - NIB_W = 4, RES_W = 8, STEPS = 4.
  - ERR_CODE = 8'hFF.
  - `uio` bit indices: START = 4, BUSY = 5, DONE = 6, ERR = 7.
- Sub-module `shift_add_step`: combinational single step mapping (acc, mcand, mplier) → next values. Instanced once in the top; the FSM, counter and handshake stay in the top.

## Test plan
- q = 5, r = 2, d = 3; start pulse → after E4, `uo_out` = 8'h11 (17), done = 1, err = 0; busy high for exactly 4 cycles.
- q = 15, r = 14, d = 15 → `uo_out` = 8'hEF (239), err = 0.
- d = 0, any q/r → after E1, `uo_out` = 8'hFF, err = 1, done = 1; no busy cycles after E1.
- q = 2, r = 5, d = 3 → `uo_out` = 8'h0B (11), err = 1.
- Handshake:
  - start held high for 10 cycles → exactly one operation.
  - New start pulse at E2 → ignored.
  - ena = 0 for 3 cycles after E1 → result appears after E7.
- rst_n low at E2 of an operation → `uo_out` = 0, `uio_out` = 0 immediately; a fresh start with q = 1, r = 0, d = 1 → 8'h01.
